// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared types and defaults for the UART transmit arbiter.
// Revision : 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_BUSY_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // Index of the set bit in a one-hot vector of up to eight bits.
    function automatic int onehot_to_idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first request after last owner.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [N_REQ-1:0] grant_o
);

    logic [IDX_W:0] idx;
    logic           found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = {1'b0, last_owner_i} + (IDX_W+1)'(off);
            if (idx >= (IDX_W+1)'(N_REQ)) begin
                idx = idx - (IDX_W+1)'(N_REQ);
            end
            if (!found && req_i[idx[IDX_W-1:0]]) begin
                grant_o[idx[IDX_W-1:0]] = 1'b1;
                found                   = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, message-locked arbiter feeding one UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_start,
    output logic [7:0]         uart_data,
    input  logic               uart_busy,
    output logic               err_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   pick;
    logic [7:0]         grant8;
    logic [IDX_W-1:0]   owner_idx;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic [CNT_W-1:0]   cnt_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_owner_i (last_owner_q),
        .grant_o      (pick)
    );

    always_comb begin
        grant8               = '0;
        grant8[N_REQ-1:0]    = grant_q;
        owner_idx            = IDX_W'(onehot_to_idx(grant8));
        owner_valid          = |(req_valid & grant_q);
        owner_data           = '0;
        owner_last           = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = req_data[8*i +: 8];
                owner_last = req_last[i];
            end
        end
        cnt_inc = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        data_d       = data_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_ready    = '0;
        uart_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Only the locked owner is offered ready; others wait for release.
                req_ready = grant_q;
                if (owner_valid) begin
                    data_d  = owner_data;
                    last_d  = owner_last;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                uart_start = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        err_d        = 1'b1;
                        grant_d      = '0;
                        last_owner_d = owner_idx;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (last_q) begin
                        last_owner_d = owner_idx;
                        grant_d      = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            data_q       <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            data_q       <= data_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign grant       = grant_q;
    assign uart_data   = data_q;
    assign err_timeout = err_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 15: maximum cycles to wait for uart_busy rise after a start pulse.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester byte-valid.
REQ-006 req_data  input  8*N_REQ  byte for requester i in bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  byte is last of a message; sampled with the byte.
REQ-008 req_ready  output  N_REQ  byte accepted when req_valid[i] & req_ready[i].
REQ-009 grant  output  N_REQ  one-hot owner of the transmitter; all zero when unowned.
REQ-010 uart_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 uart_data  output  8  byte to the transmitter; stable from start until the byte completes.
REQ-012 uart_busy  input  1  transmitter busy; rises the cycle after uart_start, falls after stop bit.
REQ-013 err_timeout  output  1  sticky; set when uart_busy fails to rise in time.

Function
REQ-014 States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any req_valid, grant the first set requester searching round-robin from (last_owner+1) mod N_REQ; register grant and go to LOAD next edge.
REQ-016 IDLE with no req_valid: grant stays zero; outputs idle.
REQ-017 LOAD: req_ready = grant & {N_REQ{state==LOAD}}, combinational; req_ready is zero in all other states.
REQ-018 LOAD transfer (valid & ready of owner): capture byte into uart_data, capture req_last into last_q, go to START.
REQ-019 LOAD without owner valid: remain in LOAD, grant held (message lock); other requesters ignored.
REQ-020 START: uart_start = 1 for exactly one cycle; clear timeout counter; go to WAIT_BUSY.
REQ-021 WAIT_BUSY: uart_busy=1 -> WAIT_DONE; else increment counter; counter reaching BUSY_TIMEOUT -> set err_timeout, clear grant, record last_owner, go to IDLE.
REQ-022 WAIT_DONE: uart_busy=0 -> if last_q: record last_owner, clear grant, go to IDLE; else go to LOAD with grant held.
REQ-023 A new request arriving while a message is locked is served only after the lock releases; round-robin guarantees each continuously requesting requester is granted within N_REQ messages.
REQ-024 Single-byte message (req_last=1 on first byte) releases the lock after that byte.
REQ-025 uart_start never asserts while uart_busy=1 or outside START.
REQ-026 Round-robin pointer wraps from N_REQ-1 to 0.
REQ-027 Timeout counter width is ceil(log2(BUSY_TIMEOUT+1)); no overflow past BUSY_TIMEOUT.

Reset
REQ-028 rst_n low forces state IDLE, grant=0, req_ready=0, uart_start=0, uart_data=0, last_q=0, counter=0, err_timeout=0, last_owner=N_REQ-1 (first search starts at 0).
REQ-029 Reset mid-byte abandons the byte and lock immediately; no uart_start pulse follows deassertion until a fresh request.
REQ-030 err_timeout clears only on reset.

Structure
REQ-031 State encoding enum and default N_REQ/BUSY_TIMEOUT constants live in the shared UART package.
REQ-032 One sub-module: rr_pick (combinational round-robin one-hot picker: request vector, last_owner -> one-hot).
REQ-033 Transmitter itself is instantiated outside this block; top level connects uart_start/uart_data/uart_busy.

Verification
REQ-034 Single request: req 0 sends 0xA5 with last=1 -> grant=0001, one uart_start, uart_data=0xA5, grant=0 after busy falls.
REQ-035 Fairness: all four request single bytes continuously -> grant order 0,1,2,3,0; no requester skipped.
REQ-036 Lock: req 1 sends 0x11,0x22,0x33 (last on 0x33) while req 2 valid -> three bytes from 1 consecutively, then 2 granted.
REQ-037 Timeout: uart_busy tied low -> err_timeout set 15 cycles after the WAIT_BUSY entry, grant cleared, next requester served.
REQ-038 Reset mid-message: rst_n low during WAIT_DONE of byte 2 of 3 -> all outputs at reset values, pointer restarts at requester 0.
REQ-039 Stalled owner: locked requester drops valid for 50 cycles -> grant held, req_ready only to owner, no uart_start until valid returns.
